// File: rtl/rsa_pkg.sv
// Shared constants and FSM encoding for the RSA key-generation / mod-exp controller.
package rsa_pkg;
  localparam int          RSA_WIDTH = 256;
  localparam int unsigned RSA_E     = 32'd65537;

  typedef enum logic [2:0] {
    LOAD      = 3'd0,
    KEYGEN    = 3'd1,
    KEY_READY = 3'd2,
    EXP       = 3'd3,
    DONE      = 3'd4
  } state_t;
endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiply: r = (a*b) mod n on a full 2*WIDTH-bit product; r = 0 when n = 0.
module mod_mul #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r
);
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    r    = '0;
    if (n != '0) r = WIDTH'(prod % {{WIDTH{1'b0}}, n});
  end
endmodule

// File: rtl/rsa_control.sv
// RSA controller: key generation (n, phi, d) after reset, then WIDTH-cycle square-and-multiply per reset1.
// Optional RSA_MSG_RANGE_CHECK_EN: a message >= n skips exponentiation and returns 0.
module rsa_control
  import rsa_pkg::*;
#(
  parameter int          WIDTH = RSA_WIDTH,
  parameter int unsigned E     = RSA_E
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic             reset1,
  input  logic             encrypt_decrypt,
  input  logic [WIDTH-1:0] msg_in,
  output logic [WIDTH-1:0] msg_out,
  output logic             mod_exp_finish
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t                  state;
  logic [WIDTH-1:0]        n, phi, d;
  logic [WIDTH-1:0]        r0, r1;
  logic signed [WIDTH+1:0] t0, t1;
  logic [WIDTH-1:0]        exp_r, base, acc;
  logic [CW-1:0]           cnt;
  logic                    pending;

  logic [WIDTH-1:0]        n_next, phi_next, quo, rem_e, msg_mod, exp_sel, acc_init;
  logic [WIDTH-1:0]        acc_mul, base_sq;
  logic signed [WIDTH+1:0] t_next;
  logic                    start;

  always_comb begin
    n_next   = p * q;
    phi_next = (p - WIDTH'(1)) * (q - WIDTH'(1));
    quo      = '0;
    rem_e    = '0;
    if (r1 != '0) begin
      quo   = r0 / r1;
      rem_e = r0 % r1;
    end
    t_next   = t0 - signed'({2'b00, quo}) * t1;
    msg_mod  = '0;
    if (n != '0) msg_mod = msg_in % n;
    exp_sel  = encrypt_decrypt ? WIDTH'(E) : d;
    // 1 mod 1 is 0, so a zero exponent must still give a reduced result.
    acc_init = (n == WIDTH'(1)) ? '0 : WIDTH'(1);
    start    = reset1 || (state == KEY_READY && pending);
  end

  mod_mul #(.WIDTH(WIDTH)) u_mul_acc (.a(acc),  .b(base), .n(n), .r(acc_mul));
  mod_mul #(.WIDTH(WIDTH)) u_mul_sq  (.a(base), .b(base), .n(n), .r(base_sq));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= LOAD;
      msg_out        <= '0;
      mod_exp_finish <= 1'b0;
      n              <= '0;
      phi            <= '0;
      d              <= '0;
      r0             <= '0;
      r1             <= '0;
      t0             <= '0;
      t1             <= '0;
      exp_r          <= '0;
      base           <= '0;
      acc            <= '0;
      cnt            <= '0;
      pending        <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          n       <= n_next;
          phi     <= phi_next;
          r0      <= phi_next;
          r1      <= WIDTH'(E);
          t0      <= '0;
          t1      <= (WIDTH+2)'(1);
          pending <= pending | reset1;
          state   <= KEYGEN;
        end
        KEYGEN: begin
          pending <= pending | reset1;
          if (r1 == '0) begin
            d     <= t0[WIDTH+1] ? WIDTH'(t0 + signed'({2'b00, phi})) : WIDTH'(t0);
            state <= KEY_READY;
          end else begin
            r0 <= r1;
            r1 <= rem_e;
            t0 <= t1;
            t1 <= t_next;
          end
        end
        KEY_READY, EXP, DONE: begin
          if (start) begin
            pending        <= 1'b0;
            mod_exp_finish <= 1'b0;
            exp_r          <= exp_sel;
            base           <= msg_mod;
            acc            <= acc_init;
            cnt            <= '0;
            state          <= EXP;
`ifdef RSA_MSG_RANGE_CHECK_EN
            if (msg_in >= n) begin
              acc   <= '0;
              state <= DONE;
            end
`endif
          end else if (state == EXP) begin
            // Fixed WIDTH iterations keep latency independent of the exponent.
            if (exp_r[0]) acc <= acc_mul;
            base  <= base_sq;
            exp_r <= exp_r >> 1;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= DONE;
          end else if (state == DONE) begin
            msg_out        <= acc;
            mod_exp_finish <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_control.sv
// Directed bench for rsa_control: a 16-bit instance (E=17) and a default 256-bit instance, scoreboard-checked.
module tb_rsa_control;
  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, go_a, enc_a, fin_a;
  logic [15:0]  p_a, q_a, msg_a, out_a;
  logic         rst_b, go_b, enc_b, fin_b;
  logic [255:0] p_b, q_b, msg_b, out_b;

  rsa_control #(.WIDTH(16), .E(17)) dut_a (
    .clk(clk), .reset(rst_a), .p(p_a), .q(q_a), .reset1(go_a),
    .encrypt_decrypt(enc_a), .msg_in(msg_a), .msg_out(out_a), .mod_exp_finish(fin_a)
  );

  rsa_control dut_b (
    .clk(clk), .reset(rst_b), .p(p_b), .q(q_b), .reset1(go_b),
    .encrypt_decrypt(enc_b), .msg_in(msg_b), .msg_out(out_b), .mod_exp_finish(fin_b)
  );

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [255:0] sb_a[$];
  logic [255:0] sb_b[$];
  logic [255:0] n_big, msg_big, ct_big, exp_rng;

  function automatic logic [255:0] mod_pow(input logic [255:0] b, input logic [255:0] e,
                                           input logic [255:0] m);
    logic [511:0] r, bb, mm;
    mm = {256'b0, m};
    r  = 512'd1 % mm;
    bb = {256'b0, b} % mm;
    for (int i = 255; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    return r[255:0];
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic start(input bit sel, input bit enc, input logic [255:0] m,
                       input bit push, input logic [255:0] expv);
    @(negedge clk);
    if (!sel) begin
      go_a = 1'b1; enc_a = enc; msg_a = m[15:0];
      if (push) sb_a.push_back(expv);
    end else begin
      go_b = 1'b1; enc_b = enc; msg_b = m;
      if (push) sb_b.push_back(expv);
    end
    @(posedge clk);
    #1;
    go_a = 1'b0;
    go_b = 1'b0;
    chk("finish_low_after_start", sel ? {255'b0, fin_b} : {255'b0, fin_a}, 256'd0);
  endtask

  task automatic wait_done(input bit sel, input int lat);
    int           cyc;
    bit           got;
    logic [255:0] expv;
    cyc = 0;
    got = 1'b0;
    for (int k = 0; k < 600 && !got; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if ((sel ? fin_b : fin_a) === 1'b1) got = 1'b1;
    end
    chk("finish_timeout", {255'b0, got}, 256'd1);
    if (got && lat >= 0) chk("finish_latency", 256'(cyc), 256'(lat));
    if (!sel) begin
      expv = (sb_a.size() > 0) ? sb_a.pop_front() : 'x;
      if (got) chk("result16", {240'b0, out_a}, expv);
    end else begin
      expv = (sb_b.size() > 0) ? sb_b.pop_front() : 'x;
      if (got) chk("result256", out_b, expv);
    end
  endtask

  initial begin
    rst_a = 1'b1; go_a = 1'b0; enc_a = 1'b0; msg_a = '0;
    rst_b = 1'b1; go_b = 1'b0; enc_b = 1'b0; msg_b = '0;
    p_a = 16'd61; q_a = 16'd53;
    p_b = 256'd113680897410347;
    q_b = 256'd7999808077935876437321;
    msg_big = 256'h48656c6c6f20576f726c6421;
    n_big   = p_b * q_b;
    ct_big  = mod_pow(msg_big, 256'd65537, n_big);

    #12;
    chk("reset_out16", {240'b0, out_a}, 256'd0);
    chk("reset_fin16", {255'b0, fin_a}, 256'd0);
    chk("reset_out256", out_b, 256'd0);
    chk("reset_fin256", {255'b0, fin_b}, 256'd0);

    // Start two cycles after release: held pending through key generation.
    @(negedge clk);
    rst_a = 1'b0;
    @(posedge clk);
    start(1'b0, 1'b1, 256'd65, 1'b1, 256'd2790);
    wait_done(1'b0, -1);

    start(1'b0, 1'b1, 256'd65, 1'b1, 256'd2790);
    wait_done(1'b0, 17);
    start(1'b0, 1'b0, 256'd2790, 1'b1, 256'd65);
    wait_done(1'b0, 17);
    start(1'b0, 1'b1, 256'd1234, 1'b1, mod_pow(256'd1234, 256'd17, 256'd3233));
    wait_done(1'b0, 17);
    start(1'b0, 1'b0, mod_pow(256'd1234, 256'd17, 256'd3233), 1'b1, 256'd1234);
    wait_done(1'b0, 17);
    start(1'b0, 1'b1, 256'd0, 1'b1, 256'd0);
    wait_done(1'b0, 17);
    start(1'b0, 1'b0, 256'd3232, 1'b1, mod_pow(256'd3232, 256'd2753, 256'd3233));
    wait_done(1'b0, 17);

    // Restart mid-exponentiation: only the second request produces a result.
    start(1'b0, 1'b1, 256'd100, 1'b0, '0);
    repeat (5) @(posedge clk);
    start(1'b0, 1'b1, 256'd200, 1'b1, mod_pow(256'd200, 256'd17, 256'd3233));
    wait_done(1'b0, 17);

`ifdef RSA_MSG_RANGE_CHECK_EN
    exp_rng = 256'd0;
`else
    exp_rng = mod_pow(256'd5, 256'd17, 256'd3233);
`endif
    start(1'b0, 1'b1, 256'd3238, 1'b1, exp_rng);
    wait_done(1'b0, -1);

    // Asynchronous reset during EXP clears outputs without waiting for a clock.
    start(1'b0, 1'b1, 256'd77, 1'b0, '0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst_a = 1'b1;
    #1;
    chk("async_reset_out", {240'b0, out_a}, 256'd0);
    chk("async_reset_fin", {255'b0, fin_a}, 256'd0);
    @(negedge clk);
    rst_a = 1'b0;
    start(1'b0, 1'b1, 256'd65, 1'b1, 256'd2790);
    wait_done(1'b0, -1);

    // 256-bit instance: key generation must finish within 100 cycles.
    @(negedge clk);
    rst_b = 1'b0;
    repeat (99) @(posedge clk);
    start(1'b1, 1'b1, msg_big, 1'b1, ct_big);
    wait_done(1'b1, 257);
    start(1'b1, 1'b0, ct_big, 1'b1, msg_big);
    wait_done(1'b1, 257);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rsa_control.md
# rsa_control

Single-clock RSA key-generation and modular-exponentiation controller. It takes two primes `p` and `q`, derives the modulus `n = p*q`, `phi = (p-1)(q-1)`, the fixed public exponent `e`, and the private exponent `d = e^-1 mod phi`. It then encrypts (`msg^e mod n`) or decrypts (`msg^d mod n`) one `WIDTH`-bit message per start pulse. It is the top-level RSA datapath/FSM of the SoC crypto path.

## Interface
- `WIDTH`, default 256: width of message, modulus and exponents. `p` and `q` each carry at most `WIDTH/2` significant bits.
- `E`, default 65537: public exponent. Must be coprime with `phi`.
- `clk` input, 1 bit: the single clock; all state on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high. Clears all state. Its deassertion launches key generation.
- `p` input, `WIDTH` bits: first prime, captured at key-gen launch.
- `q` input, `WIDTH` bits: second prime, captured at key-gen launch.
- `reset1` input, 1 bit: synchronous, active-high start pulse for one exponentiation.
- `encrypt_decrypt` input, 1 bit: 1 = encrypt with `E`, 0 = decrypt with `d`. Sampled with `reset1`.
- `msg_in` input, `WIDTH` bits: message or ciphertext, sampled with `reset1`.
- `msg_out` output, `WIDTH` bits: result. Valid while `mod_exp_finish` is high.
- `mod_exp_finish` output, 1 bit: result-ready level.

## Operation
- FSM states: LOAD, KEYGEN, KEY_READY, EXP, DONE.
- Reset forces LOAD and clears `msg_out`, `mod_exp_finish`, `n`, `d` and `phi` to 0.
- LOAD, first clock after reset release:
  - Register `n = p*q`, truncated to `WIDTH` bits, and `phi = (p-1)*(q-1)`.
  - Initialise extended Euclid with `r0 = phi`, `r1 = E`, `t0 = 0`, `t1 = 1`.
  - Go to KEYGEN.
- KEYGEN: one Euclid step per cycle. Use `WIDTH+2`-bit signed `t` coefficients.
  - When `r1 == 0`, set `d = t0` if `t0 >= 0`, else `t0 + phi`. Go to KEY_READY.
- KEY_READY: wait for `reset1`.
- On `reset1` in KEY_READY or DONE:
  - Set `exp = encrypt_decrypt ? E : d` and `base = msg_in mod n` (see Configuration).
  - Set `acc = 1` and `cnt = 0`. Clear `mod_exp_finish`. Go to EXP.
- `reset1` in LOAD or KEYGEN is latched as pending and consumed on entry to KEY_READY. Inputs are sampled at the moment of consumption.
- EXP, right-to-left square-and-multiply, one exponent bit per cycle:
  - If `exp[0]`, then `acc = acc*base mod n`.
  - `base = base*base mod n`; `exp >>= 1`; `cnt++`.
  - Runs for exactly `WIDTH` cycles, independent of exponent value.
- DONE: `msg_out = acc`, `mod_exp_finish = 1`. Both hold until the next `reset1` or `reset`.
- Arithmetic rules:
  - Products are `2*WIDTH` bits before reduction.
  - All modular results are `< n`.
  - A zero exponent yields 1, or 0 if `n == 1`.
- `reset1` during EXP restarts the exponentiation with the new inputs.

## Timing
- Key generation: 1 LOAD cycle plus the number of Euclid steps. With `E = 65537` this is at most about 30 cycles, and must complete within 100 cycles of reset release.
- Exponentiation: `mod_exp_finish` rises `WIDTH+1` clocks after the edge sampling `reset1`, i.e. 257 cycles for `WIDTH = 256`.
- `mod_exp_finish` falls on the clock after `reset1` is sampled.
- Outputs change only on clock edges, except for the asynchronous clear by `reset`.

## Configuration
- `RSA_MSG_RANGE_CHECK_EN` defined:
  - A `msg_in >= n` at start skips EXP.
  - DONE is entered the next cycle with `msg_out = 0`.
- Not defined: `msg_in` is reduced mod `n` and processed normally.

## Structure
- Package `rsa_pkg` holds:
  - the FSM state enum;
  - the default `E` constant (65537);
  - the default `WIDTH` constant.
- Sub-module `mod_mul`: combinational `(a*b) mod n`, parameterised by `WIDTH`. Instantiated twice, for accumulate and square.
- Euclid step logic stays inline.

## Test plan
- `WIDTH=16`, `E=17`, `p=61`, `q=53`, reset then start with encrypt, `msg_in=65` -> `n=3233`, `d=2753`, `msg_out=2790`, finish after 17 cycles.
- Same key, decrypt, `msg_in=2790` -> `msg_out=65`.
- `WIDTH=256`, `p=113680897410347`, `q=7999808077935876437321`, encrypt `0x48656c6c6f20576f726c6421` -> `C`; decrypt `C` -> original message; finish after 257 cycles.
- `reset1` issued 2 cycles after reset release -> held pending, result identical to a late start.
- `reset` asserted mid-EXP -> `msg_out=0` and `mod_exp_finish=0` immediately; key regenerated after release.
- `msg_in = n+5` -> with `RSA_MSG_RANGE_CHECK_EN`, `msg_out=0`; without it, result equals that for `msg_in=5`.
